// File: rtl/julia_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : julia_frame_sched
// Purpose : Raster pixel walker for the julia_iter engine: incremental 16.16
//           coordinates, start/done handshake, 4-bit quantised BRAM writes.
//           Define JULIA_SCHED_CONT_EN for continuous re-rendering.
// Rev     : 1.0
// ============================================================================
module julia_frame_sched #(
    parameter int H_RES  = 1280,
    parameter int V_RES  = 720,
    parameter int ADDR_W = 20,
    parameter int ITER_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_zoom_sel,
    input  logic              i_restart,
    output logic              o_eng_start,
    output logic [31:0]       o_eng_x,
    output logic [31:0]       o_eng_y,
    input  logic              i_eng_done,
    input  logic [ITER_W-1:0] i_eng_iter,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [3:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt
);

`ifdef JULIA_SCHED_CONT_EN
    localparam logic c_CONT = 1'b1;
`else
    localparam logic c_CONT = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam int c_XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [c_XW-1:0] c_XMAX = c_XW'(H_RES - 1);
    localparam logic [c_YW-1:0] c_YMAX = c_YW'(V_RES - 1);

    // Full spans at zoom 0: real 8.0, imaginary 4.5; each zoom step halves them.
    localparam logic [31:0] c_SPAN_X = 32'h0008_0000;
    localparam logic [31:0] c_SPAN_Y = 32'h0004_8000;
    localparam logic [31:0] c_SX0 = c_SPAN_X / 32'(H_RES - 1);
    localparam logic [31:0] c_SX1 = (c_SPAN_X >> 1) / 32'(H_RES - 1);
    localparam logic [31:0] c_SX2 = (c_SPAN_X >> 2) / 32'(H_RES - 1);
    localparam logic [31:0] c_SX3 = (c_SPAN_X >> 3) / 32'(H_RES - 1);
    localparam logic [31:0] c_SY0 = c_SPAN_Y / 32'(V_RES - 1);
    localparam logic [31:0] c_SY1 = (c_SPAN_Y >> 1) / 32'(V_RES - 1);
    localparam logic [31:0] c_SY2 = (c_SPAN_Y >> 2) / 32'(V_RES - 1);
    localparam logic [31:0] c_SY3 = (c_SPAN_Y >> 3) / 32'(V_RES - 1);

    function automatic logic [31:0] f_rmin(input logic [1:0] z);
        case (z)
            2'd0:    return 32'hFFFC_0000;
            2'd1:    return 32'hFFFE_0000;
            2'd2:    return 32'hFFFF_0000;
            default: return 32'hFFFF_8000;
        endcase
    endfunction

    function automatic logic [31:0] f_imax(input logic [1:0] z);
        case (z)
            2'd0:    return 32'h0002_4000;
            2'd1:    return 32'h0001_2000;
            2'd2:    return 32'h0000_9000;
            default: return 32'h0000_4800;
        endcase
    endfunction

    function automatic logic [31:0] f_sx(input logic [1:0] z);
        case (z)
            2'd0:    return c_SX0;
            2'd1:    return c_SX1;
            2'd2:    return c_SX2;
            default: return c_SX3;
        endcase
    endfunction

    function automatic logic [31:0] f_sy(input logic [1:0] z);
        case (z)
            2'd0:    return c_SY0;
            2'd1:    return c_SY1;
            2'd2:    return c_SY2;
            default: return c_SY3;
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_zoom_q;
    logic              r_pend;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_eng_x;
    logic [31:0]       r_eng_y;
    logic [3:0]        r_wr_data;
    logic [7:0]        r_frame_cnt;

    logic              w_go;
    logic              w_last_pix;
    logic              w_in_write;
    logic              w_load;
    logic              w_step;
    logic              w_done_ok;
    logic              w_zoom_chg;
    logic [ITER_W-5:0] w_iter_hi;
    logic [3:0]        w_quant;
    logic              w_unused_lsb;

    assign w_go       = (r_state == S_IDLE) & (i_start | i_restart);
    assign w_last_pix = (r_x == c_XMAX) & (r_y == c_YMAX);
    assign w_in_write = (r_state == S_WRITE);
    // Frame origin reload: new frame, pending restart, or continuous wrap.
    assign w_load     = w_go | (w_in_write & r_pend) | (w_in_write & ~r_pend & w_last_pix & c_CONT);
    assign w_step     = w_in_write & ~r_pend & ~w_last_pix;
    assign w_done_ok  = (r_state == S_WAIT) & i_eng_done;
    assign w_zoom_chg = (r_state != S_IDLE) & (i_zoom_sel != r_zoom_q);

    assign w_iter_hi    = i_eng_iter[ITER_W-1:4];
    assign w_quant      = (w_iter_hi > (ITER_W-4)'(15)) ? 4'hF : w_iter_hi[3:0];
    assign w_unused_lsb = ^i_eng_iter[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (i_eng_done) w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (r_pend || !w_last_pix || c_CONT) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_eng_start  = (r_state == S_ISSUE);
        o_wr_en      = w_in_write;
        o_busy       = (r_state != S_IDLE);
        o_frame_done = w_in_write & ~r_pend & w_last_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zoom_q    <= 2'd0;
            r_pend      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= '0;
            r_eng_x     <= 32'd0;
            r_eng_y     <= 32'd0;
            r_wr_data   <= 4'd0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (w_load) begin
                r_zoom_q <= i_zoom_sel;
                r_pend   <= 1'b0;
                r_x      <= '0;
                r_y      <= '0;
                r_addr   <= '0;
                r_eng_x  <= f_rmin(i_zoom_sel);
                r_eng_y  <= f_imax(i_zoom_sel);
            end else begin
                r_pend <= (r_state == S_IDLE) ? 1'b0 : (r_pend | i_restart | w_zoom_chg);
                if (w_step) begin
                    r_addr <= r_addr + 1'b1;
                    if (r_x != c_XMAX) begin
                        r_x     <= r_x + 1'b1;
                        r_eng_x <= r_eng_x + f_sx(r_zoom_q);
                    end else begin
                        r_x     <= '0;
                        r_y     <= r_y + 1'b1;
                        r_eng_x <= f_rmin(r_zoom_q);
                        r_eng_y <= r_eng_y - f_sy(r_zoom_q);
                    end
                end
            end
            if (w_done_ok) begin
                r_wr_data <= w_quant;
            end
            if (o_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign o_eng_x     = r_eng_x;
    assign o_eng_y     = r_eng_y;
    assign o_wr_addr   = r_addr;
    assign o_wr_data   = r_wr_data;
    assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
